// File: rtl/fpaddsub_normalize_seq.sv
// Sequential normalization stage between the mantissa adder and the rounder.
// Optional FPADDSUB_NORM_FASTPATH_EN: already-normalized inputs skip the NORM cycle.
module fpaddsub_normalize_seq #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        InSgn,
    input  logic [1:0]  InRoundMode,
    input  logic [7:0]  InE,
    input  logic [26:0] InM,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Sgn,
    output logic [1:0]  RoundMode,
    output logic [8:0]  NormE,
    output logic [22:0] NormM,
    output logic        R,
    output logic        S
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [8:0] STEP = 9'(SHIFT_STEP);

    state_t      state_r, state_s;
    logic [26:0] m_r, m_s;
    logic [8:0]  e_r, e_s;
    logic        sgn_r, sgn_s;
    logic [1:0]  rm_r, rm_s;
    logic [8:0]  k_s;

    // Leading zeros of the 26-bit hidden+fraction+guard+sticky field, from bit 25 down.
    function automatic logic [4:0] lzc26(input logic [25:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 25; i >= 0; i--) begin
            if (hit) begin
                n = n;
            end else if (v[i]) begin
                hit = 1'b1;
            end else begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Next-state and datapath update: one normalization rule per NORM cycle.
    always_comb begin
        state_s = state_r;
        m_s     = m_r;
        e_s     = e_r;
        sgn_s   = sgn_r;
        rm_s    = rm_r;
        k_s     = {4'd0, lzc26(m_r[25:0])};
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    m_s   = InM;
                    e_s   = {1'b0, InE};
                    sgn_s = InSgn;
                    rm_s  = InRoundMode;
`ifdef FPADDSUB_NORM_FASTPATH_EN
                    if (InM[26:25] == 2'b01) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_NORM;
                    end
`else
                    state_s = ST_NORM;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (m_r[26]) begin
                    // carry-out: one right shift, the dropped bit folds into sticky
                    m_s     = {1'b0, m_r[26:2], m_r[1] | m_r[0]};
                    e_s     = e_r + 9'd1;
                    state_s = ST_DONE;
                end else if (m_r[25]) begin
                    state_s = ST_DONE;
                end else if (m_r == 27'd0) begin
                    e_s     = 9'd0;
                    state_s = ST_DONE;
                end else if (e_r <= 9'd1) begin
                    e_s     = 9'd0;
                    state_s = ST_DONE;
                end else begin
                    if (k_s > STEP) begin
                        k_s = STEP;
                    end else begin
                        k_s = k_s;
                    end
                    // never shift below exponent 1 (denormal boundary)
                    if (k_s > (e_r - 9'd1)) begin
                        k_s = e_r - 9'd1;
                    end else begin
                        k_s = k_s;
                    end
                    m_s     = m_r << k_s;
                    e_s     = e_r - k_s;
                    state_s = ST_NORM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            m_r     <= 27'd0;
            e_r     <= 9'd0;
            sgn_r   <= 1'b0;
            rm_r    <= 2'b00;
        end else begin
            state_r <= state_s;
            m_r     <= m_s;
            e_r     <= e_s;
            sgn_r   <= sgn_s;
            rm_r    <= rm_s;
        end
    end

    assign in_ready  = (state_r == ST_IDLE) && !rst;
    assign out_valid = (state_r == ST_DONE);
    assign Sgn       = sgn_r;
    assign RoundMode = rm_r;
    assign NormE     = e_r;
    assign NormM     = m_r[24:2];
    assign R         = m_r[1];
    assign S         = m_r[0];

endmodule

// File: tb/tb_fpaddsub_normalize_seq.sv
// Self-checking bench for fpaddsub_normalize_seq: directed cases plus random operands
// checked against a bit-at-a-time reference model.
module tb_fpaddsub_normalize_seq;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        InSgn;
    logic [1:0]  InRoundMode;
    logic [7:0]  InE;
    logic [26:0] InM;
    logic        out_valid;
    logic        out_ready;
    logic        Sgn;
    logic [1:0]  RoundMode;
    logic [8:0]  NormE;
    logic [22:0] NormM;
    logic        R;
    logic        S;

    int checks = 0;
    int errors = 0;

    fpaddsub_normalize_seq #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .InSgn(InSgn), .InRoundMode(InRoundMode), .InE(InE), .InM(InM),
        .out_valid(out_valid), .out_ready(out_ready), .Sgn(Sgn), .RoundMode(RoundMode),
        .NormE(NormE), .NormM(NormM), .R(R), .S(S)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  e;
        logic [26:0] m;
        int          lat;
    } ref_t;

    // Reference: shift one bit at a time until hidden bit set or exponent reaches 1.
    function automatic ref_t model(input logic [7:0] ein, input logic [26:0] min);
        ref_t        r;
        int          e;
        int          n;
        logic [26:0] m;
        e = int'(ein);
        m = min;
        n = 0;
        r.lat = 2;
        if (m[26]) begin
            m = (m >> 1) | (m & 27'd1);
            e = e + 1;
        end else if (m[25]) begin
            e = e;
        end else if (m == 27'd0) begin
            e = 0;
        end else if (e <= 1) begin
            e = 0;
        end else begin
            while (!m[25] && e > 1) begin
                m = m << 1;
                e = e - 1;
                n = n + 1;
            end
            if (!m[25]) e = 0;
            r.lat = 2 + (n + STEP - 1) / STEP;
        end
`ifdef FPADDSUB_NORM_FASTPATH_EN
        if (min[26:25] == 2'b01) r.lat = 1;
`endif
        r.e = 9'(e);
        r.m = m;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic sg, input logic [1:0] rm, input ref_t ex);
        chk({tag, " NormE"}, 32'(NormE), 32'(ex.e));
        chk({tag, " NormM"}, 32'(NormM), 32'(ex.m[24:2]));
        chk({tag, " R"}, 32'(R), 32'(ex.m[1]));
        chk({tag, " S"}, 32'(S), 32'(ex.m[0]));
        chk({tag, " Sgn"}, 32'(Sgn), 32'(sg));
        chk({tag, " RoundMode"}, 32'(RoundMode), 32'(rm));
    endtask

    // One operation: accept, wait for out_valid (bounded), check, stall 'hold' cycles, handshake.
    task automatic run_txn(input string tag, input logic sg, input logic [1:0] rm,
                           input logic [7:0] e, input logic [26:0] m, input int hold);
        ref_t ex;
        int   lat;
        ex = model(e, m);
        @(negedge clk);
        chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        InSgn = sg; InRoundMode = rm; InE = e; InM = m; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // keep offering junk while busy; it must not be captured
        InSgn = ~sg; InRoundMode = ~rm; InE = 8'($urandom); InM = 27'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(ex.lat));
        check_outputs(tag, sg, rm, ex);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " held in_ready"}, 32'(in_ready), 32'd0);
            check_outputs({tag, " held"}, sg, rm, ex);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        InSgn = 1'b0; InRoundMode = 2'b00; InE = 8'd0; InM = 27'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset NormE", 32'(NormE), 32'd0);
        chk("reset NormM", 32'(NormM), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", 32'(in_ready), 32'd1);

        run_txn("T1 normalized", 1'b0, 2'b00, 8'h7F, 27'h2000000, 0);
        run_txn("T2 carry", 1'b0, 2'b01, 8'h7F, 27'h4000003, 0);
        run_txn("T3 deep cancel", 1'b1, 2'b11, 8'h7F, 27'h0000004, 3);
        run_txn("T4 denormal floor", 1'b0, 2'b00, 8'h02, 27'h0400000, 0);
        run_txn("T5 zero", 1'b1, 2'b10, 8'h55, 27'h0000000, 1);
        run_txn("carry from 255", 1'b0, 2'b00, 8'hFF, 27'h7FFFFFF, 0);
        run_txn("exponent one", 1'b0, 2'b00, 8'h01, 27'h0000100, 0);

        // reset in the middle of a deep cancellation
        @(negedge clk);
        InSgn = 1'b1; InRoundMode = 2'b11; InE = 8'h7F; InM = 27'h0000004; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midop rst out_valid", 32'(out_valid), 32'd0);
        chk("midop rst in_ready", 32'(in_ready), 32'd0);
        chk("midop rst Sgn", 32'(Sgn), 32'd0);
        chk("midop rst RoundMode", 32'(RoundMode), 32'd0);
        chk("midop rst NormE", 32'(NormE), 32'd0);
        chk("midop rst NormM", 32'(NormM), 32'd0);
        chk("midop rst R", 32'(R), 32'd0);
        chk("midop rst S", 32'(S), 32'd0);
        rst = 1'b0;
        #1;
        chk("midop rst in_ready release", 32'(in_ready), 32'd1);

        for (int t = 0; t < 60; t++) begin
            logic [26:0] rm_m;
            rm_m = 27'($urandom) >> $urandom_range(0, 26);
            run_txn("random", 1'($urandom), 2'($urandom), 8'($urandom), rm_m,
                    int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
